mux41_rr_arb: RTL and testbench

Round-robin arbiter that shares one MUX41 4:1 select primitive between four requesters. It drives the mux selects SD1/SD2 and returns a one-hot grant. Tenure is bounded by a hold limit. An optional guard cycle keeps select changes from overlapping an active grant. It sits beside each shared MUX41 instance, with SD1/SD2 wired directly to the primitive's select pins.

---
 rtl/mux41_arb_pkg.sv | 28 ++
 rtl/mux41_rr_arb_rr_pick4.sv | 43 ++++
 rtl/mux41_rr_arb.sv | 148 ++++++++++++++
 tb/tb_mux41_rr_arb.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux41_arb_pkg.sv
// Shared types and helpers for the MUX41 round-robin select arbiter.
package mux41_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_OWN   = 2'd2
    } arb_state_e;

    localparam logic [1:0] SEL_D0 = 2'd0;
    localparam logic [1:0] SEL_D1 = 2'd1;
    localparam logic [1:0] SEL_D2 = 2'd2;
    localparam logic [1:0] SEL_D3 = 2'd3;

    // Map a 2-bit mux select index onto the matching one-hot grant vector.
    function automatic logic [3:0] idx2onehot(input logic [1:0] idx);
        logic [3:0] oh;
        case (idx)
            SEL_D0:  oh = 4'b0001;
            SEL_D1:  oh = 4'b0010;
            SEL_D2:  oh = 4'b0100;
            SEL_D3:  oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mux41_rr_arb_rr_pick4.sv
// Combinational round-robin pick: first eligible request starting at ptr_i.
module rr_pick4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    input  logic [3:0] mask_i,
    output logic       any_o,
    output logic [1:0] idx_o
);

    logic [3:0] elig_s;
    logic [3:0] rot_s;
    logic [1:0] off_s;

    // Rotate eligible requests so the pointer position lands on bit 0.
    always_comb begin
        elig_s = req_i & ~mask_i;
        case (ptr_i)
            2'd0:    rot_s = elig_s;
            2'd1:    rot_s = {elig_s[0],   elig_s[3:1]};
            2'd2:    rot_s = {elig_s[1:0], elig_s[3:2]};
            2'd3:    rot_s = {elig_s[2:0], elig_s[3]};
            default: rot_s = elig_s;
        endcase
    end

    // Find the first set bit of the rotated vector and undo the rotation.
    always_comb begin
        any_o = 1'b1;
        off_s = 2'd0;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: begin
                any_o = 1'b0;
                off_s = 2'd0;
            end
        endcase
        idx_o = ptr_i + off_s;
    end

endmodule

// File: rtl/mux41_rr_arb.sv
// Round-robin arbiter driving the select pins of a shared MUX41 primitive,
// with bounded tenure and an optional dead cycle on select changes.
module mux41_rr_arb
    import mux41_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int GUARD    = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] req_i,
    output logic [3:0] gnt_o,
    output logic       sd1_o,
    output logic       sd2_o,
    output logic       active_o
);

    localparam int             HCW      = $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HC_MAX   = HCW'(MAX_HOLD);
    localparam logic [HCW-1:0] HC_ONE   = HCW'(1);
    localparam logic           GUARD_EN = (GUARD != 0);

    arb_state_e     state_q;
    logic [1:0]     ptr_q;
    logic [1:0]     w_q;
    logic [1:0]     sel_q;
    logic [HCW-1:0] hc_q;
    logic [3:0]     gnt_q;
    logic           active_q;

    logic [3:0] own_oh_s;
    logic [1:0] pick_ptr_s;
    logic [3:0] pick_mask_s;
    logic       pick_any_s;
    logic [1:0] pick_idx_s;
    logic       at_limit_s;
    logic       rivals_s;
    logic       release_s;
    logic       need_guard_s;

    // Choose arbitration context: plain scan when idle, owner masked and
    // pointer advanced past the owner when deciding a handover.
    always_comb begin
        own_oh_s = idx2onehot(w_q);
        if (state_q == ST_OWN) begin
            pick_ptr_s  = w_q + 2'd1;
            pick_mask_s = own_oh_s;
        end else begin
            pick_ptr_s  = ptr_q;
            pick_mask_s = 4'b0000;
        end
        at_limit_s   = (hc_q == HC_MAX);
        rivals_s     = |(req_i & ~own_oh_s);
        release_s    = ~req_i[w_q] | (at_limit_s & rivals_s);
        need_guard_s = GUARD_EN & (pick_idx_s != sel_q);
    end

    rr_pick4 u_pick (
        .req_i  (req_i),
        .ptr_i  (pick_ptr_s),
        .mask_i (pick_mask_s),
        .any_o  (pick_any_s),
        .idx_o  (pick_idx_s)
    );

    // Arbitration FSM with registered grant, select and active outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 2'd0;
            w_q      <= 2'd0;
            sel_q    <= SEL_D0;
            hc_q     <= '0;
            gnt_q    <= 4'b0000;
            active_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        w_q   <= pick_idx_s;
                        sel_q <= pick_idx_s;
                        if (need_guard_s) begin
                            state_q  <= ST_GUARD;
                            gnt_q    <= 4'b0000;
                            active_q <= 1'b0;
                        end else begin
                            state_q  <= ST_OWN;
                            gnt_q    <= idx2onehot(pick_idx_s);
                            active_q <= 1'b1;
                            hc_q     <= HC_ONE;
                        end
                    end else begin
                        gnt_q    <= 4'b0000;
                        active_q <= 1'b0;
                    end
                end
                ST_GUARD: begin
                    if (req_i[w_q]) begin
                        state_q  <= ST_OWN;
                        gnt_q    <= own_oh_s;
                        active_q <= 1'b1;
                        hc_q     <= HC_ONE;
                    end else begin
                        state_q  <= ST_IDLE;
                        gnt_q    <= 4'b0000;
                        active_q <= 1'b0;
                    end
                end
                ST_OWN: begin
                    if (release_s) begin
                        ptr_q <= w_q + 2'd1;
                        if (pick_any_s) begin
                            w_q   <= pick_idx_s;
                            sel_q <= pick_idx_s;
                            if (need_guard_s) begin
                                state_q  <= ST_GUARD;
                                gnt_q    <= 4'b0000;
                                active_q <= 1'b0;
                            end else begin
                                state_q  <= ST_OWN;
                                gnt_q    <= idx2onehot(pick_idx_s);
                                active_q <= 1'b1;
                                hc_q     <= HC_ONE;
                            end
                        end else begin
                            state_q  <= ST_IDLE;
                            gnt_q    <= 4'b0000;
                            active_q <= 1'b0;
                        end
                    end else begin
                        hc_q <= at_limit_s ? HC_ONE : (hc_q + HC_ONE);
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    gnt_q    <= 4'b0000;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o    = gnt_q;
    assign sd1_o    = sel_q[0];
    assign sd2_o    = sel_q[1];
    assign active_o = active_q;

endmodule

// File: tb/tb_mux41_rr_arb.sv
// Self-checking bench: two arbiter instances (MAX_HOLD=3/GUARD=0 and
// MAX_HOLD=4/GUARD=1) share stimulus; every cycle is compared to a
// behavioural model, plus a hand-derived vector table and corner sequences.
module tb_mux41_rr_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;

    logic [3:0] gnt_a, gnt_b;
    logic       sd1_a, sd2_a, act_a;
    logic       sd1_b, sd2_b, act_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux41_rr_arb #(.MAX_HOLD(3), .GUARD(0)) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .gnt_o(gnt_a), .sd1_o(sd1_a), .sd2_o(sd2_a), .active_o(act_a)
    );

    mux41_rr_arb #(.MAX_HOLD(4), .GUARD(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .gnt_o(gnt_b), .sd1_o(sd1_b), .sd2_o(sd2_b), .active_o(act_b)
    );

    // Behavioural model: who owns the mux, who is waiting out a dead cycle,
    // where the round-robin scan starts, what the mux selects, tenure length.
    typedef struct {
        int owner;
        int pend;
        int ptr;
        int sel;
        int ten;
    } mdl_t;

    mdl_t ma, mb;

    function automatic int pick(input logic [3:0] r, input int start, input int excl);
        for (int i = 0; i < 4; i++) begin
            int j;
            j = (start + i) % 4;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    function automatic mdl_t award(input mdl_t m, input int w, input bit guard);
        mdl_t n;
        n = m;
        if (guard && w != n.sel) begin
            n.pend = w;
        end else begin
            n.owner = w;
            n.ten   = 1;
        end
        n.sel = w;
        return n;
    endfunction

    function automatic mdl_t step(input mdl_t m, input logic [3:0] r, input logic rs,
                                  input int maxh, input bit guard);
        mdl_t n;
        int   w;
        logic [3:0] others;
        n = m;
        if (rs) begin
            n.owner = -1; n.pend = -1; n.ptr = 0; n.sel = 0; n.ten = 0;
        end else if (n.owner >= 0) begin
            others = r & ~(4'b0001 << n.owner);
            if (!r[n.owner] || (n.ten == maxh && others != 4'b0000)) begin
                n.ptr = (n.owner + 1) % 4;
                w = pick(r, n.ptr, n.owner);
                n.owner = -1;
                if (w >= 0) n = award(n, w, guard);
            end else begin
                n.ten = (n.ten == maxh) ? 1 : n.ten + 1;
            end
        end else if (n.pend >= 0) begin
            if (r[n.pend]) begin
                n.owner = n.pend;
                n.ten   = 1;
            end
            n.pend = -1;
        end else begin
            w = pick(r, n.ptr, -1);
            if (w >= 0) n = award(n, w, guard);
        end
        return n;
    endfunction

    function automatic logic [3:0] mgnt(input mdl_t m);
        return (m.owner >= 0) ? (4'b0001 << m.owner) : 4'b0000;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance both models with the inputs the DUTs sample, then
    // compare every output of both instances shortly after the edge.
    task automatic tick();
        @(posedge clk);
        ma = step(ma, req, rst, 3, 1'b0);
        mb = step(mb, req, rst, 4, 1'b1);
        #1;
        check("mdl_a_gnt", {4'b0000, gnt_a}, {4'b0000, mgnt(ma)});
        check("mdl_a_sel", {6'd0, sd2_a, sd1_a}, 8'(ma.sel));
        check("mdl_a_act", {7'd0, act_a}, {7'd0, (ma.owner >= 0)});
        check("mdl_b_gnt", {4'b0000, gnt_b}, {4'b0000, mgnt(mb)});
        check("mdl_b_sel", {6'd0, sd2_b, sd1_b}, 8'(mb.sel));
        check("mdl_b_act", {7'd0, act_b}, {7'd0, (mb.owner >= 0)});
    endtask

    task automatic drive(input logic r, input logic [3:0] q);
        rst = r;
        req = q;
        tick();
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] ga;
        logic [3:0] gb;
        logic [1:0] sb;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] ga,
                                input logic [3:0] gb, input logic [1:0] sb);
        vec_t v;
        v.rst = r; v.req = q; v.ga = ga; v.gb = gb; v.sb = sb;
        return v;
    endfunction

    initial begin
        ma = '{-1, -1, 0, 0, 0};
        mb = '{-1, -1, 0, 0, 0};

        // Reset with all requests, then REQ=1111 held: A rotates every 3
        // cycles with no gap, B every 4 cycles with a dead cycle between.
        tbl[0]  = mk(1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0);
        tbl[1]  = mk(1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0);
        tbl[2]  = mk(1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0);
        tbl[3]  = mk(1'b0, 4'b1111, 4'b0001, 4'b0001, 2'd0);
        tbl[4]  = mk(1'b0, 4'b1111, 4'b0001, 4'b0001, 2'd0);
        tbl[5]  = mk(1'b0, 4'b1111, 4'b0001, 4'b0001, 2'd0);
        tbl[6]  = mk(1'b0, 4'b1111, 4'b0010, 4'b0001, 2'd0);
        tbl[7]  = mk(1'b0, 4'b1111, 4'b0010, 4'b0000, 2'd1);
        tbl[8]  = mk(1'b0, 4'b1111, 4'b0010, 4'b0010, 2'd1);
        tbl[9]  = mk(1'b0, 4'b1111, 4'b0100, 4'b0010, 2'd1);
        tbl[10] = mk(1'b0, 4'b1111, 4'b0100, 4'b0010, 2'd1);
        tbl[11] = mk(1'b0, 4'b1111, 4'b0100, 4'b0010, 2'd1);
        tbl[12] = mk(1'b0, 4'b1111, 4'b1000, 4'b0000, 2'd2);
        tbl[13] = mk(1'b0, 4'b1111, 4'b1000, 4'b0100, 2'd2);
        tbl[14] = mk(1'b0, 4'b1111, 4'b1000, 4'b0100, 2'd2);
        tbl[15] = mk(1'b0, 4'b1111, 4'b0001, 4'b0100, 2'd2);
        tbl[16] = mk(1'b0, 4'b1111, 4'b0001, 4'b0100, 2'd2);
        tbl[17] = mk(1'b0, 4'b1111, 4'b0001, 4'b0000, 2'd3);
        tbl[18] = mk(1'b0, 4'b1111, 4'b0010, 4'b1000, 2'd3);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst, tbl[i].req);
            check($sformatf("tbl%0d_a_gnt", i), {4'b0000, gnt_a}, {4'b0000, tbl[i].ga});
            check($sformatf("tbl%0d_b_gnt", i), {4'b0000, gnt_b}, {4'b0000, tbl[i].gb});
            check($sformatf("tbl%0d_b_sel", i), {6'd0, sd2_b, sd1_b}, {6'd0, tbl[i].sb});
        end

        // Index change from 00 to 10: B inserts one dead cycle, A does not.
        drive(1'b1, 4'b0000);
        drive(1'b0, 4'b0100);
        check("guard_b_gap_gnt", {4'b0000, gnt_b}, 8'h00);
        check("guard_b_gap_sel", {6'd0, sd2_b, sd1_b}, 8'h02);
        check("guard_a_direct",  {4'b0000, gnt_a}, 8'h04);
        drive(1'b0, 4'b0100);
        check("guard_b_grant",   {4'b0000, gnt_b}, 8'h04);

        // Owner 2 drops after two granted cycles while requester 0 waits.
        drive(1'b1, 4'b0000);
        drive(1'b0, 4'b0100);
        drive(1'b0, 4'b0101);
        check("early_b_own1", {4'b0000, gnt_b}, 8'h04);
        drive(1'b0, 4'b0101);
        check("early_b_own2", {4'b0000, gnt_b}, 8'h04);
        drive(1'b0, 4'b0001);
        check("early_b_gap",  {4'b0000, gnt_b}, 8'h00);
        check("early_b_sel",  {6'd0, sd2_b, sd1_b}, 8'h00);
        drive(1'b0, 4'b0001);
        check("early_b_next", {4'b0000, gnt_b}, 8'h01);

        // Request withdrawn during the dead cycle: back to idle, select kept;
        // re-request on the same index is granted with no dead cycle.
        drive(1'b1, 4'b0000);
        drive(1'b0, 4'b0100);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 4'b0000);
            check("drop_b_gnt", {4'b0000, gnt_b}, 8'h00);
            check("drop_b_sel", {6'd0, sd2_b, sd1_b}, 8'h02);
            check("drop_b_act", {7'd0, act_b}, 8'h00);
        end
        drive(1'b0, 4'b0100);
        check("drop_b_regrant", {4'b0000, gnt_b}, 8'h04);

        // Lone requester keeps the grant across hold-limit renewals.
        drive(1'b1, 4'b0000);
        drive(1'b0, 4'b0010);
        drive(1'b0, 4'b0010);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 4'b0010);
            check("hold_b_gnt", {4'b0000, gnt_b}, 8'h02);
            check("hold_b_act", {7'd0, act_b}, 8'h01);
            check("hold_a_gnt", {4'b0000, gnt_a}, 8'h02);
        end

        // Reset while requester 3 owns (pointer at 3); pointer must return to 0.
        drive(1'b1, 4'b0000);
        for (int i = 0; i < 3; i++) drive(1'b0, 4'b0100);
        for (int i = 0; i < 3; i++) drive(1'b0, 4'b1000);
        check("midrst_pre_a", {4'b0000, gnt_a}, 8'h08);
        check("midrst_pre_b", {4'b0000, gnt_b}, 8'h08);
        drive(1'b1, 4'b1000);
        check("midrst_a_gnt", {4'b0000, gnt_a}, 8'h00);
        check("midrst_b_gnt", {4'b0000, gnt_b}, 8'h00);
        check("midrst_b_sel", {6'd0, sd2_b, sd1_b}, 8'h00);
        check("midrst_b_act", {7'd0, act_b}, 8'h00);
        drive(1'b0, 4'b1001);
        check("midrst_ptr_a", {4'b0000, gnt_a}, 8'h01);
        check("midrst_ptr_b", {4'b0000, gnt_b}, 8'h01);

        // Randomised traffic with held request patterns and rare resets.
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic [3:0] q;
            r = ($urandom_range(0, 149) == 0);
            q = req;
            if ($urandom_range(0, 3) == 0) q = 4'($urandom_range(0, 15));
            drive(r, q);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
